// File: rtl/btn_irq_pkg.sv
// btn_irq_pkg: shared state encoding and default sizing for the button interrupt controller
package btn_irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int NUM_BTN_DEF = 4;
    localparam logic [NUM_BTN_DEF-1:0] MASK_RST_DEF = '1;

endpackage

// File: rtl/btn_irq_prio_sel.sv
// btn_irq_prio_sel: picks one source from the candidate set, fixed lowest-index or round-robin from ptr
module btn_irq_prio_sel
    import btn_irq_pkg::*;
#(
    parameter int NUM_BTN = NUM_BTN_DEF,
    parameter int ID_W    = $clog2(NUM_BTN)
) (
    input  logic [NUM_BTN-1:0] cand,
    input  logic [ID_W-1:0]    ptr,
    input  logic               rr_en,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [ID_W-1:0] idx;

    // scan from the farthest offset down so the nearest candidate is written last and wins
    always_comb begin
        valid = |cand;
        id    = '0;
        idx   = '0;
        for (int k = NUM_BTN - 1; k >= 0; k--) begin
            idx = rr_en ? ID_W'((int'(ptr) + k) % NUM_BTN) : ID_W'(k);
            if (cand[idx]) id = idx;
        end
    end

endmodule

// File: rtl/btn_irq_ctrl.sv
// btn_irq_ctrl: latches button press pulses as pending requests and presents one interrupt at a time
module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int                 NUM_BTN  = NUM_BTN_DEF,
    parameter int                 ID_W     = $clog2(NUM_BTN),
    parameter int                 RR_EN    = 0,
    parameter logic [NUM_BTN-1:0] MASK_RST = {NUM_BTN{1'b1}}
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_tick_i,
    input  logic [NUM_BTN-1:0] btn_level_i,
    input  logic               mask_we_i,
    input  logic [NUM_BTN-1:0] mask_wdata_i,
    input  logic [NUM_BTN-1:0] pend_clr_i,
    input  logic               irq_ack_i,
    input  logic               irq_eoi_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o,
    output logic [NUM_BTN-1:0] pending_o,
    output logic [NUM_BTN-1:0] mask_o,
    output logic [NUM_BTN-1:0] overrun_o,
    output logic [NUM_BTN-1:0] level_o
);

    state_t             state;
    logic               irq;
    logic [ID_W-1:0]    id;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_nxt;
    logic [ID_W-1:0]    sel_id;
    logic               sel_valid;
    logic [NUM_BTN-1:0] pending;
    logic [NUM_BTN-1:0] mask;
    logic [NUM_BTN-1:0] overrun;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] cand;
    logic [NUM_BTN-1:0] ack_vec;
    logic [NUM_BTN-1:0] keep;

    assign ack_vec = (state == REQ && irq_ack_i) ? NUM_BTN'(1) << id : '0;
    assign keep    = ~pend_clr_i & ~ack_vec;
    assign cand    = pending & mask;
    assign ptr_nxt = (id == ID_W'(NUM_BTN - 1)) ? '0 : id + 1'b1;

    btn_irq_prio_sel #(
        .NUM_BTN(NUM_BTN),
        .ID_W   (ID_W)
    ) u_sel (
        .cand (cand),
        .ptr  (ptr),
        .rr_en(RR_EN != 0),
        .valid(sel_valid),
        .id   (sel_id)
    );

    // a new press always wins over a clear or ack landing in the same cycle
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            pending <= '0;
            overrun <= '0;
            mask    <= MASK_RST;
            level   <= '0;
        end else begin
            pending <= btn_tick_i | (pending & keep);
            overrun <= (overrun & ~pend_clr_i) | (btn_tick_i & pending & keep);
            level   <= btn_level_i;
            if (mask_we_i) mask <= mask_wdata_i;
        end
    end

    // request/ack/eoi handshake; a request whose source is cleared or masked is withdrawn
    always_ff @(posedge clk_50MHz) begin
        if (!rst_n) begin
            state <= IDLE;
            irq   <= 1'b0;
            id    <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: if (sel_valid) begin
                    id    <= sel_id;
                    irq   <= 1'b1;
                    state <= REQ;
                end
                REQ: if (irq_ack_i) begin
                    irq   <= 1'b0;
                    state <= SERVICE;
                end else if (!pending[id] || !mask[id]) begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
                SERVICE: if (irq_eoi_i) begin
                    state <= IDLE;
                    if (RR_EN != 0) ptr <= ptr_nxt;
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign irq_o     = irq;
    assign irq_id_o  = id;
    assign pending_o = pending;
    assign mask_o    = mask;
    assign overrun_o = overrun;
    assign level_o   = level;

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// tb_btn_irq_ctrl: scoreboard bench for btn_irq_ctrl, fixed-priority and round-robin instances
module tb_btn_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] tick, level, mask_wd, clr;
    logic       mask_we, ack, eoi;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend, mask, ovr, lvl;

    logic [3:0] tick_r;
    logic       ack_r, eoi_r;
    logic       irq_r;
    logic [1:0] id_r;
    logic [3:0] pend_r, mask_r, ovr_r, lvl_r;

    int n_run = 0;
    int n_fail = 0;
    int mon_run = 0;
    int mon_fail = 0;
    int q[$];
    int rq[$];
    logic irq_q = 1'b0;
    logic irq_rq = 1'b0;

    always #5 clk = ~clk;

    btn_irq_ctrl #(.NUM_BTN(4), .RR_EN(0)) dut (
        .clk_50MHz(clk), .rst_n(rst_n), .btn_tick_i(tick), .btn_level_i(level),
        .mask_we_i(mask_we), .mask_wdata_i(mask_wd), .pend_clr_i(clr),
        .irq_ack_i(ack), .irq_eoi_i(eoi), .irq_o(irq), .irq_id_o(id),
        .pending_o(pend), .mask_o(mask), .overrun_o(ovr), .level_o(lvl)
    );

    btn_irq_ctrl #(.NUM_BTN(4), .RR_EN(1)) dut_rr (
        .clk_50MHz(clk), .rst_n(rst_n), .btn_tick_i(tick_r), .btn_level_i(4'h0),
        .mask_we_i(1'b0), .mask_wdata_i(4'h0), .pend_clr_i(4'h0),
        .irq_ack_i(ack_r), .irq_eoi_i(eoi_r), .irq_o(irq_r), .irq_id_o(id_r),
        .pending_o(pend_r), .mask_o(mask_r), .overrun_o(ovr_r), .level_o(lvl_r)
    );

    // each rising irq is one presented interrupt; its ID must match the next expected one
    always @(negedge clk) begin
        int e;
        if (rst_n && irq && !irq_q) begin
            mon_run++;
            if (q.size() == 0) begin
                mon_fail++;
                $display("FAIL irq_id: got id %0d, none expected", id);
            end else begin
                e = q.pop_front();
                if (int'(id) != e) begin
                    mon_fail++;
                    $display("FAIL irq_id: got %0d expected %0d", id, e);
                end
            end
        end
        if (rst_n && irq_r && !irq_rq) begin
            mon_run++;
            if (rq.size() == 0) begin
                mon_fail++;
                $display("FAIL rr_id: got id %0d, none expected", id_r);
            end else begin
                e = rq.pop_front();
                if (int'(id_r) != e) begin
                    mon_fail++;
                    $display("FAIL rr_id: got %0d expected %0d", id_r, e);
                end
            end
        end
        irq_q  = irq;
        irq_rq = irq_r;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic serve();
        ack = 1'b1;
        nxt();
        ack = 1'b0;
        eoi = 1'b1;
        nxt();
        eoi = 1'b0;
        nxt();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; tick = 4'hF; level = 4'hA; mask_we = 1'b0; mask_wd = 4'h0;
        clr = 4'h0; ack = 1'b0; eoi = 1'b0; tick_r = 4'hF; ack_r = 1'b0; eoi_r = 1'b0;
        repeat (2) nxt();
        chk("rst_irq", irq, 0);
        chk("rst_id", id, 0);
        chk("rst_pend", pend, 4'h0);
        chk("rst_ovr", ovr, 4'h0);
        chk("rst_lvl", lvl, 4'h0);
        chk("rst_mask", mask, 4'hF);
        chk("rst_rr_pend", pend_r, 4'h0);
        rst_n = 1'b1; tick = 4'h0; tick_r = 4'h0; level = 4'h0;
        nxt();

        tick = 4'b0100; level = 4'b0110; q.push_back(2);
        nxt();
        tick = 4'h0;
        chk("press_pend", pend, 4'b0100);
        chk("press_irq_early", irq, 0);
        chk("level_lag", lvl, 4'b0110);
        nxt();
        chk("press_irq", irq, 1);
        chk("press_id", id, 2);
        nxt(); nxt();
        chk("req_hold", irq, 1);
        ack = 1'b1;
        nxt();
        ack = 1'b0;
        chk("ack_irq", irq, 0);
        chk("ack_pend", pend, 4'h0);
        nxt(); nxt();
        eoi = 1'b1;
        nxt();
        eoi = 1'b0;
        chk("eoi_irq", irq, 0);
        nxt();
        chk("idle_quiet", irq, 0);

        tick = 4'b1010; q.push_back(1); q.push_back(3);
        nxt();
        tick = 4'h0;
        chk("fp_pend", pend, 4'b1010);
        nxt();
        chk("fp_irq1", irq, 1);
        chk("fp_id1", id, 1);
        ack = 1'b1;
        nxt();
        ack = 1'b0;
        chk("fp_ack_pend", pend, 4'b1000);
        chk("fp_ack_irq", irq, 0);
        eoi = 1'b1;
        nxt();
        eoi = 1'b0;
        chk("fp_gap_low", irq, 0);
        nxt();
        chk("fp_irq3", irq, 1);
        chk("fp_id3", id, 3);
        serve();
        chk("fp_done_pend", pend, 4'h0);

        tick = 4'b0001; q.push_back(0);
        nxt();
        tick = 4'h0;
        nxt();
        chk("wd_irq_up", irq, 1);
        clr = 4'b0001;
        nxt();
        clr = 4'h0;
        chk("wd_pend", pend, 4'h0);
        nxt();
        chk("wd_irq_fall", irq, 0);
        ack = 1'b1;
        nxt();
        ack = 1'b0;
        nxt(); nxt();
        chk("wd_quiet", irq, 0);

        mask_we = 1'b1; mask_wd = 4'b1110;
        nxt();
        mask_we = 1'b0;
        chk("mask_wr", mask, 4'b1110);
        tick = 4'b0001;
        nxt();
        tick = 4'h0;
        chk("mask_pend", pend, 4'b0001);
        nxt(); nxt();
        chk("mask_block", irq, 0);
        mask_we = 1'b1; mask_wd = 4'hF; q.push_back(0);
        nxt();
        mask_we = 1'b0;
        chk("mask_en_wait", irq, 0);
        nxt();
        chk("mask_en_irq", irq, 1);
        mask_we = 1'b1; mask_wd = 4'b1110;
        nxt();
        mask_we = 1'b0;
        nxt();
        chk("mask_wd_irq", irq, 0);
        chk("mask_wd_pend", pend, 4'b0001);
        mask_we = 1'b1; mask_wd = 4'hF; q.push_back(0);
        nxt();
        mask_we = 1'b0;
        nxt();
        chk("mask_re_irq", irq, 1);
        ack = 1'b1; mask_we = 1'b1; mask_wd = 4'b1110;
        nxt();
        ack = 1'b0; mask_we = 1'b0;
        chk("mask_ack_pend", pend, 4'h0);
        chk("mask_ack_irq", irq, 0);
        chk("mask_ack_mask", mask, 4'b1110);
        eoi = 1'b1;
        nxt();
        eoi = 1'b0; mask_we = 1'b1; mask_wd = 4'hF;
        nxt();
        mask_we = 1'b0;

        tick = 4'b0010; q.push_back(1);
        nxt();
        nxt();
        tick = 4'h0;
        chk("ovr_set", ovr, 4'b0010);
        chk("ovr_irq", irq, 1);
        clr = 4'b0010;
        nxt();
        clr = 4'h0;
        chk("ovr_clr", ovr, 4'h0);
        chk("ovr_clr_pend", pend, 4'h0);
        nxt();
        chk("ovr_wd_irq", irq, 0);
        tick = 4'b0010; q.push_back(1);
        nxt();
        tick = 4'h0;
        nxt();
        chk("col_irq", irq, 1);
        ack = 1'b1; tick = 4'b0010;
        nxt();
        ack = 1'b0; tick = 4'h0;
        chk("col_pend", pend, 4'b0010);
        chk("col_ovr", ovr, 4'h0);
        chk("col_irq_low", irq, 0);
        eoi = 1'b1; q.push_back(1);
        nxt();
        eoi = 1'b0;
        nxt();
        chk("col_re_irq", irq, 1);
        chk("col_re_id", id, 1);
        serve();
        chk("col_done_pend", pend, 4'h0);

        rq.push_back(0); rq.push_back(1); rq.push_back(0); rq.push_back(1); rq.push_back(0);
        tick_r = 4'b0011;
        nxt();
        tick_r = 4'h0;
        for (int s = 0; s < 5; s++) begin
            int w = 0;
            while (!irq_r && w < 10) begin
                nxt();
                w++;
            end
            chk("rr_wait", irq_r, 1);
            ack_r = 1'b1;
            nxt();
            ack_r = 1'b0;
            if (s < 3) tick_r = 4'b0011;
            nxt();
            tick_r = 4'h0; eoi_r = 1'b1;
            nxt();
            eoi_r = 1'b0;
        end
        nxt(); nxt();
        chk("rr_done_pend", pend_r, 4'h0);
        chk("rr_quiet", irq_r, 0);
        chk("q_empty", q.size(), 0);
        chk("rq_empty", rq.size(), 0);

        n_run += mon_run;
        n_fail += mon_fail;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_irq_ctrl.md
# btn_irq_ctrl

Interrupt controller for the kit's push-buttons. It collects the one-cycle debounced press pulses from the per-button debouncers and latches them as pending requests. It arbitrates among the enabled pending requests and presents exactly one interrupt at a time to the RISC core's interrupt input, using a request/acknowledge/end-of-interrupt handshake. It sits between the button debouncers and the CPU interrupt handler.

## Interface
- NUM_BTN, 4: number of button sources, range 2..8.
- ID_W, $clog2(NUM_BTN): width of the interrupt ID.
- RR_EN, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- MASK_RST, {NUM_BTN{1'b1}}: reset value of the enable mask.

- clk_50MHz  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- btn_tick_i  in  NUM_BTN  one-cycle press pulses from the debouncers.
- btn_level_i  in  NUM_BTN  debounced button levels; status only.
- mask_we_i  in  1  load mask_wdata_i into the mask.
- mask_wdata_i  in  NUM_BTN  new mask value (1 = enabled).
- pend_clr_i  in  NUM_BTN  write-1-to-clear for pending and overrun bits.
- irq_ack_i  in  1  CPU acknowledges the presented interrupt.
- irq_eoi_i  in  1  CPU signals end of service.
- irq_o  out  1  interrupt request, registered.
- irq_id_o  out  ID_W  index of the presented source, registered.
- pending_o  out  NUM_BTN  pending register.
- mask_o  out  NUM_BTN  mask register.
- overrun_o  out  NUM_BTN  sticky flag: a press arrived while that source was already pending.
- level_o  out  NUM_BTN  btn_level_i registered once.

## Operation
- Reset (rst_n=0 at a clock edge) sets:
  - state = IDLE, irq_o = 0, irq_id_o = 0;
  - pending = 0, overrun = 0, level_o = 0;
  - mask = MASK_RST, round-robin pointer = 0.
- Reset asserted in any state aborts the operation in progress; no interrupt is pending afterwards.
- Pending update, per bit i, in priority order:
  1. btn_tick_i[i] sets pending[i].
  2. Otherwise pend_clr_i[i] clears it.
  3. Otherwise an ack that selects i clears it.
- Tick wins over a simultaneous clear or ack; no overrun is flagged in that case.
- Overrun: btn_tick_i[i] while pending[i]=1 and no clear/ack of i in the same cycle sets overrun[i]. Only pend_clr_i[i] clears it.
- Mask changes pending only indirectly; masked sources still latch pending.
- Candidate set = pending & mask.
  - Fixed priority: lowest set index.
  - Round-robin: first set index at or above the pointer, wrapping modulo NUM_BTN.
- FSM:
  - IDLE: if the candidate set ≠ 0, latch the selected ID into irq_id_o, set irq_o=1, go to REQ.
  - REQ: irq_o=1 and irq_id_o are held stable.
    - If irq_ack_i: clear pending[id], set irq_o=0, go to SERVICE.
    - Else if pending[id]=0 or mask[id]=0 (withdrawn): set irq_o=0, go to IDLE.
  - SERVICE: irq_o=0. On irq_eoi_i go to IDLE; if RR_EN, pointer = (id+1) mod NUM_BTN.
- irq_ack_i outside REQ and irq_eoi_i outside SERVICE are ignored.
- Nested interrupts are not supported; presses during SERVICE only accumulate as pending.

## Timing
- Tick at edge t: pending visible after t. Earliest irq_o=1 is after edge t+1, a 2-cycle latency.
- Ack sampled at edge a: irq_o=0 and pending[id]=0 after a.
- EOI sampled at edge e: state IDLE after e. The next irq_o can rise after e+1, so irq_o is low for at least 1 cycle between interrupts.
- Withdraw: irq_o falls one edge after the pending/mask condition becomes false. irq_o is never high with a stale ID.
- Mask write takes effect at the next edge. A mask write and an ack in the same cycle: the ack is honoured.
- level_o lags btn_level_i by 1 cycle.

## Structure
- Package btn_irq_pkg:
  - state enum typedef (IDLE, REQ, SERVICE);
  - default NUM_BTN and MASK_RST constants.
- Sub-module btn_irq_prio_sel: combinational selector.
  - Inputs: candidate vector, pointer, RR_EN.
  - Outputs: valid, ID.
  - Instantiated once.
- Debouncers are instantiated outside this block, one per button.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with ticks active -> all outputs 0, mask_o=4'b1111.
- Single press: tick on btn 2 at cycle 10 -> pending_o=4'b0100 at 11, irq_o=1 with irq_id_o=2 at 12. Ack at 15 -> irq_o=0, pending_o=0. EOI at 20 -> IDLE.
- Fixed priority: ticks on btn 3 and btn 1 in the same cycle -> ID 1 served first. After EOI, ID 3 is presented with irq_o low for exactly 1 cycle between the two.
- Round-robin (RR_EN=1): btns 0 and 1 re-pressed every service, 4 services -> ID sequence 0,1,0,1.
- Withdraw: in REQ with ID 0, pend_clr_i=4'b0001 -> irq_o falls next cycle, state IDLE, no ack required.
- Overrun and collision:
  - second tick on btn 1 while pending -> overrun_o[1]=1;
  - tick coincident with ack of the same ID -> pending stays 1, overrun_o stays 0.
